min_max_dist_top: RTL and testbench
===================================

// Module: min_max_dist_top
// PURPOSE
//  - Top-level engine for the pairwise-distance kernel.
//  - Reads 32 signed 16-bit values from an embedded byte-wide data memory.
//  - Finds the minimum and maximum |a-b| over all 496 distinct pairs.
//  - Writes both results back to the same memory.
//  - Hardwired FSM, no instruction fetch. Bench preloads and inspects memory hierarchically.
// PARAMETERS
//  - N_VALS    32   number of 16-bit operands (pairs = N_VALS*(N_VALS-1)/2 = 496)
//  - DM_DEPTH  256  data memory depth in bytes
// PORTS
//  - clk    input  1  single clock; all state updates on rising edge
//  - rst_n  input  1  asynchronous, active-low reset
//  - start  input  1  run request; high = hold/idle, a run begins once start is sampled low
//  - done   output 1  acknowledge; high when results are written, held until start returns high
// BEHAVIOUR
//  - Memory: instance name dm, array dm.core[0:DM_DEPTH-1] of 8-bit bytes.
//    - Combinational read, synchronous write, one port.
//    - Contents are not touched by reset.
//  - Operand layout: value i = {core[2i], core[2i+1]} (big-endian), i = 0..31, two's complement.
//  - Result layout:
//    - Min = {core[66], core[67]}
//    - Max = {core[68], core[69]}
//    - Bytes 64:65 are scratch; the design need not preserve them.
//    - All other bytes are unmodified (except under the optional feature).
//  - Distance: diff = a - b, computed 17-bit signed; dist = diff[16] ? -diff : diff, low 16 bits.
//    - Range is 0..65535 with no overflow (e.g. 32767 vs -32768 -> 65535).
//  - Comparison:
//    - Running min starts at 16'hFFFF and updates on strict dist < min.
//    - Running max starts at 16'h0000 and updates on strict dist > max.
//    - Ties keep the first pair in (j<k, j outer, k inner) order.
//  - FSM states: IDLE -> LOAD -> CMP -> WR -> DONE.
//    - IDLE: done=0. Move to LOAD on the first edge with start==0.
//    - LOAD: 64 cycles, one byte per cycle, filling a 32x16 register file.
//    - CMP: 496 cycles, one (j,k) pair per cycle, k = j+1..31.
//    - WR: 4 cycles, writing core[66], [67], [68], [69] in that order.
//    - DONE: done=1, held while start==0. Return to IDLE (done=0) on the edge with start==1.
//  - Latency: done rises 565 clocks after the edge that first samples start==0.
//  - A start that stays low after DONE does not retrigger a run; a high-then-low cycle is required.
//  - start changes during LOAD/CMP/WR are ignored; the run always completes.
//  - Reset, any state: state=IDLE, done=0, min=FFFF, max=0, counters=0.
//    - Reset mid-run aborts the run with no further memory writes.
//    - Bytes already written stay written.
// CONFIGURATION
//  - MINMAX_IDX_EN defined: also track pair indices and write them in WR.
//    - core[70] = min j, core[71] = min k, core[72] = max j, core[73] = max k.
//    - WR becomes 8 cycles and latency becomes 569.
//  - MINMAX_IDX_EN undefined: no index registers; core[70:73] untouched; latency 565.
// TESTING
//  - All 32 values = 0 -> Min=0, Max=0, done high after 565 clocks.
//  - Values i = 0..31 -> Min=1, Max=31.
//  - value0=32767, value1=-32768, rest=0 -> Max=65535, Min=0.
//  - Values 1000*i (i = 0..31), with value7 duplicated into value20 -> Min=0, Max=31000.
//  - Reset pulsed mid-CMP, then a new run -> done low during reset, correct results after the rerun.
//  - Ten back-to-back runs with start high->low toggles and new data -> all Min/Max correct; no done glitch while start high.

Source files
------------

// File: rtl/min_max_dist_top.sv
// Pairwise-distance engine: loads 32 signed 16-bit values from the byte memory dm,
// finds the min/max |a-b| over all distinct pairs and writes both back. Option: MINMAX_IDX_EN.

module min_max_dist_dm #(
   parameter int DM_DEPTH = 256,
   parameter int AW       = $clog2(DM_DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [7:0]    i_wdata,
   output logic [7:0]    o_rdata
);
   logic [7:0] core [0:DM_DEPTH-1];

   always_ff @(posedge clk) begin
      if (i_we) core[i_addr] <= i_wdata;
   end

   assign o_rdata = core[i_addr];
endmodule

module min_max_dist_top #(
   parameter int N_VALS   = 32,
   parameter int DM_DEPTH = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic done
);
   localparam int AW = $clog2(DM_DEPTH);
   localparam int IW = $clog2(N_VALS);
`ifdef MINMAX_IDX_EN
   localparam logic [5:0] WR_LAST = 6'd7;
`else
   localparam logic [5:0] WR_LAST = 6'd3;
`endif
   localparam logic [5:0]    LOAD_LAST = 6'(2 * N_VALS - 1);
   localparam logic [IW-1:0] J_LAST    = IW'(N_VALS - 2);
   localparam logic [IW-1:0] K_LAST    = IW'(N_VALS - 1);
   localparam logic [AW-1:0] RES_BASE  = AW'(66);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CMP, S_WR, S_DONE} state_t;

   state_t        r_state, w_state_next;
   logic [5:0]    r_cnt, w_cnt_next;
   logic [IW-1:0] r_j, r_k, w_j_next, w_k_next;
   logic [15:0]   r_min, r_max, w_min_next, w_max_next;
   logic          r_done, w_done_next;
   logic [15:0]   r_vals [0:N_VALS-1];

   logic [AW-1:0] w_addr;
   logic          w_we;
   logic [7:0]    w_wdata, w_rdata;
   logic [15:0]   w_a, w_b, w_dist;
   logic [16:0]   w_diff;
   logic          w_min_upd, w_max_upd;

   min_max_dist_dm #(.DM_DEPTH(DM_DEPTH)) dm (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata)
   );

   // Register file fill: even byte is the high half (big-endian operands).
   always_ff @(posedge clk) begin
      if (r_state == S_LOAD) begin
         if (r_cnt[0]) r_vals[r_cnt[IW:1]][7:0]  <= w_rdata;
         else          r_vals[r_cnt[IW:1]][15:8] <= w_rdata;
      end
   end

   assign w_a       = r_vals[r_j];
   assign w_b       = r_vals[r_k];
   assign w_diff    = {w_a[15], w_a} - {w_b[15], w_b};
   assign w_dist    = w_diff[16] ? (~w_diff[15:0] + 16'd1) : w_diff[15:0];
   assign w_min_upd = (r_state == S_CMP) && (w_dist < r_min);
   assign w_max_upd = (r_state == S_CMP) && (w_dist > r_max);

   assign w_we   = (r_state == S_WR);
   assign w_addr = (r_state == S_LOAD) ? AW'(r_cnt) : RES_BASE + AW'(r_cnt[2:0]);

`ifdef MINMAX_IDX_EN
   logic [IW-1:0] r_min_j, r_min_k, r_max_j, r_max_k;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_min_j <= '0;
         r_min_k <= '0;
         r_max_j <= '0;
         r_max_k <= '0;
      end else begin
         if (w_min_upd) begin
            r_min_j <= r_j;
            r_min_k <= r_k;
         end
         if (w_max_upd) begin
            r_max_j <= r_j;
            r_max_k <= r_k;
         end
      end
   end
`endif

   always_comb begin
      w_wdata = 8'h00;
      case (r_cnt[2:0])
         3'd0: w_wdata = r_min[15:8];
         3'd1: w_wdata = r_min[7:0];
         3'd2: w_wdata = r_max[15:8];
         3'd3: w_wdata = r_max[7:0];
`ifdef MINMAX_IDX_EN
         3'd4: w_wdata = 8'(r_min_j);
         3'd5: w_wdata = 8'(r_min_k);
         3'd6: w_wdata = 8'(r_max_j);
         3'd7: w_wdata = 8'(r_max_k);
`endif
         default: w_wdata = 8'h00;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_j_next     = r_j;
      w_k_next     = r_k;
      w_min_next   = r_min;
      w_max_next   = r_max;
      w_done_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!start) begin
               w_state_next = S_LOAD;
               w_cnt_next   = '0;
               w_j_next     = '0;
               w_k_next     = IW'(1);
               w_min_next   = 16'hFFFF;
               w_max_next   = 16'h0000;
            end
         end
         S_LOAD: begin
            w_cnt_next = r_cnt + 6'd1;
            if (r_cnt == LOAD_LAST) begin
               w_state_next = S_CMP;
               w_cnt_next   = '0;
            end
         end
         S_CMP: begin
            if (w_min_upd) w_min_next = w_dist;
            if (w_max_upd) w_max_next = w_dist;
            if (r_k == K_LAST) begin
               if (r_j == J_LAST) begin
                  w_state_next = S_WR;
                  w_cnt_next   = '0;
               end else begin
                  w_j_next = r_j + IW'(1);
                  w_k_next = r_j + IW'(2);
               end
            end else begin
               w_k_next = r_k + IW'(1);
            end
         end
         S_WR: begin
            w_cnt_next = r_cnt + 6'd1;
            if (r_cnt == WR_LAST) w_state_next = S_DONE;
         end
         S_DONE: begin
            // done is registered, so it appears one edge after entering DONE.
            if (start) w_state_next = S_IDLE;
            else       w_done_next  = 1'b1;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_min   <= 16'hFFFF;
         r_max   <= 16'h0000;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_j     <= w_j_next;
         r_k     <= w_k_next;
         r_min   <= w_min_next;
         r_max   <= w_max_next;
         r_done  <= w_done_next;
      end
   end

   assign done = r_done;
endmodule

// File: tb/tb_min_max_dist_top.sv
// Self-checking bench for min_max_dist_top: directed and random operand sets checked
// against a plain nested-loop reference model (index checks when MINMAX_IDX_EN is defined).

module tb_min_max_dist_top;
   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic done;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef MINMAX_IDX_EN
   localparam int LAT = 569;
`else
   localparam int LAT = 565;
`endif

   logic [15:0] vals [32];
   logic [7:0]  img  [256];
   int exp_min, exp_max, exp_mnj, exp_mnk, exp_mxj, exp_mxk;

   min_max_dist_top dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: smallest/largest absolute difference over all j<k, first occurrence wins.
   task automatic model();
      int a, b, d;
      exp_min = 65535; exp_max = 0;
      exp_mnj = 0; exp_mnk = 0; exp_mxj = 0; exp_mxk = 0;
      for (int j = 0; j < 32; j++) begin
         for (int k = j + 1; k < 32; k++) begin
            a = int'($signed(vals[j]));
            b = int'($signed(vals[k]));
            d = (a > b) ? a - b : b - a;
            if (d < exp_min) begin exp_min = d; exp_mnj = j; exp_mnk = k; end
            if (d > exp_max) begin exp_max = d; exp_mxj = j; exp_mxk = k; end
         end
      end
   endtask

   task automatic load_image();
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      for (int i = 0; i < 32; i++) begin
         img[2*i]   = vals[i][15:8];
         img[2*i+1] = vals[i][7:0];
      end
      for (int i = 0; i < 256; i++) dut.dm.core[i] = img[i];
   endtask

   task automatic do_run(input string tag);
      int cyc;
      int bad;
      logic [15:0] got;
      model();
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      cyc = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(LAT));
      got = {dut.dm.core[66], dut.dm.core[67]};
      check({tag, "_min"}, 32'(got), 32'(exp_min));
      got = {dut.dm.core[68], dut.dm.core[69]};
      check({tag, "_max"}, 32'(got), 32'(exp_max));
      bad = 0;
`ifdef MINMAX_IDX_EN
      check({tag, "_min_j"}, 32'(dut.dm.core[70]), 32'(exp_mnj));
      check({tag, "_min_k"}, 32'(dut.dm.core[71]), 32'(exp_mnk));
      check({tag, "_max_j"}, 32'(dut.dm.core[72]), 32'(exp_mxj));
      check({tag, "_max_k"}, 32'(dut.dm.core[73]), 32'(exp_mxk));
      for (int i = 0; i < 256; i++)
         if (!(i >= 64 && i <= 73) && dut.dm.core[i] !== img[i]) bad++;
`else
      for (int i = 0; i < 256; i++)
         if (!(i >= 64 && i <= 69) && dut.dm.core[i] !== img[i]) bad++;
`endif
      check({tag, "_untouched"}, 32'(bad), 32'd0);
      repeat (6) @(posedge clk);
      #1 check({tag, "_done_held"}, 32'(done), 32'd1);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      check({tag, "_done_clear"}, 32'(done), 32'd0);
      $display("[TB] run %s: min=%0d max=%0d latency=%0d", tag, exp_min, exp_max, cyc);
   endtask

   initial begin
      int gap;
      rst_n = 1'b0;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("reset_done", 32'(done), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 check("idle_done", 32'(done), 32'd0);

      for (int i = 0; i < 32; i++) vals[i] = 16'd0;
      load_image();
      do_run("zeros");

      for (int i = 0; i < 32; i++) vals[i] = 16'(i);
      load_image();
      do_run("ramp");

      for (int i = 0; i < 32; i++) vals[i] = 16'd0;
      vals[0] = 16'h7FFF;
      vals[1] = 16'h8000;
      load_image();
      do_run("extremes");

      for (int i = 0; i < 32; i++) vals[i] = 16'(1000 * i);
      vals[20] = vals[7];
      load_image();
      do_run("dup");

      // Reset in the middle of CMP must abort without touching the result bytes.
      for (int i = 0; i < 32; i++) vals[i] = 16'($urandom);
      load_image();
      @(negedge clk); start = 1'b0;
      repeat (200) @(posedge clk);
      @(negedge clk); rst_n = 1'b0; start = 1'b1;
      #1 check("midreset_done", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1 check("midreset_done_hold", 32'(done), 32'd0);
      check("midreset_nowrite", {dut.dm.core[66], dut.dm.core[67], dut.dm.core[68], dut.dm.core[69]},
            {img[66], img[67], img[68], img[69]});
      @(negedge clk); rst_n = 1'b1;
      load_image();
      do_run("rerun");

      for (int r = 0; r < 10; r++) begin
         gap = int'($urandom_range(1, 4));
         for (int c = 0; c < gap; c++) begin
            @(posedge clk); #1;
            check($sformatf("b2b%0d_idle_done", r), 32'(done), 32'd0);
         end
         for (int i = 0; i < 32; i++)
            vals[i] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 300) - 150);
         load_image();
         do_run($sformatf("b2b%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
